banco_varredura: RTL and testbench

Eight-entry register bank with scan sequencer, directly upstream of the 8:1 byte multiplexer. Holds the eight data bytes presented on `E0`..`E7` and drives the 3-bit select `Sinal`, stepping it through a programmable index range under a valid/ready handshake with the consumer of `Saida`. Supports single-pass and cyclic scans, wrap-around ranges and abort.

---
 rtl/banco_varredura.sv | 136 +++++++++++++
 tb/tb_banco_varredura.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/banco_varredura.sv
// banco_varredura: eight-entry register bank plus a scan sequencer that steps
// the 8:1 multiplexer select through a programmable index range under a
// valid/ready handshake. Single-pass, cyclic, wrap-around and abort supported.

// One bank entry: synchronous clear, write-enabled load.
module banco_entrada #(
    parameter int LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);
    // Entry storage; reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= d;
    end
endmodule

module banco_varredura #(
    parameter int LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [LARGURA-1:0] wr_data,
    input  logic               iniciar,
    input  logic [2:0]         primeiro,
    input  logic [2:0]         ultimo,
    input  logic               ciclico,
    input  logic               parar,
    input  logic               pronto,
    output logic [LARGURA-1:0] E0,
    output logic [LARGURA-1:0] E1,
    output logic [LARGURA-1:0] E2,
    output logic [LARGURA-1:0] E3,
    output logic [LARGURA-1:0] E4,
    output logic [LARGURA-1:0] E5,
    output logic [LARGURA-1:0] E6,
    output logic [LARGURA-1:0] E7,
    output logic [2:0]         Sinal,
    output logic               valido,
    output logic               ocupado,
    output logic               fim
);
    typedef enum logic [1:0] {OCIOSO, VARRENDO, FIM} estado_t;

    estado_t                  estado, prox;
    logic [2:0]               sinal_prox;
    logic [2:0]               prim_l, ult_l;
    logic                     cic_l;
    logic                     transf;
    logic [7:0][LARGURA-1:0]  banco;

    // Bank: one entry instance per index, decoded write enable.
    for (genvar g = 0; g < 8; g++) begin : g_banco
        banco_entrada #(.LARGURA(LARGURA)) u_ent (
            .clk (clk),
            .rst (rst),
            .we  (wr_en && (wr_addr == 3'(g))),
            .d   (wr_data),
            .q   (banco[g])
        );
    end

    assign E0 = banco[0];
    assign E1 = banco[1];
    assign E2 = banco[2];
    assign E3 = banco[3];
    assign E4 = banco[4];
    assign E5 = banco[5];
    assign E6 = banco[6];
    assign E7 = banco[7];

    // valido is a register that mirrors VARRENDO, so it is safe to use here.
    assign transf = valido && pronto;

    // Next state and next select; parar outranks a coincident transfer.
    always_comb begin
        prox       = estado;
        sinal_prox = Sinal;
        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    prox       = VARRENDO;
                    sinal_prox = primeiro;
                end
            end
            VARRENDO: begin
                if (parar) begin
                    prox = OCIOSO;
                end else if (transf) begin
                    if (Sinal != ult_l) sinal_prox = Sinal + 3'd1;
                    else if (cic_l)     sinal_prox = prim_l;
                    else                prox       = FIM;
                end
            end
            FIM:     prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    // State, select and status flags; flags are decoded from the next state
    // so every output leaves a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= OCIOSO;
            Sinal   <= '0;
            valido  <= 1'b0;
            ocupado <= 1'b0;
            fim     <= 1'b0;
        end else begin
            estado  <= prox;
            Sinal   <= sinal_prox;
            valido  <= (prox == VARRENDO);
            ocupado <= (prox != OCIOSO);
            fim     <= (prox == FIM);
        end
    end

    // Scan range is captured only when a start is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            prim_l <= '0;
            ult_l  <= '0;
            cic_l  <= 1'b0;
        end else if (estado == OCIOSO && iniciar) begin
            prim_l <= primeiro;
            ult_l  <= ultimo;
            cic_l  <= ciclico;
        end
    end
endmodule

// File: tb/tb_banco_varredura.sv
// Directed bench for banco_varredura: vector table for reset, bank load and a
// single pass, then hand sequences for wrap/backpressure, cyclic abort,
// ignored start with mid-scan write, and reset mid-scan.
module tb_banco_varredura;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       iniciar = 1'b0;
    logic [2:0] primeiro = '0;
    logic [2:0] ultimo = '0;
    logic       ciclico = 1'b0;
    logic       parar = 1'b0;
    logic       pronto = 1'b0;
    logic [7:0] E0, E1, E2, E3, E4, E5, E6, E7;
    logic [2:0] Sinal;
    logic       valido, ocupado, fim;
    logic [7:0][7:0] e_all;

    int total = 0;
    int bad   = 0;

    banco_varredura #(.LARGURA(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iniciar(iniciar), .primeiro(primeiro), .ultimo(ultimo), .ciclico(ciclico),
        .parar(parar), .pronto(pronto),
        .E0(E0), .E1(E1), .E2(E2), .E3(E3), .E4(E4), .E5(E5), .E6(E6), .E7(E7),
        .Sinal(Sinal), .valido(valido), .ocupado(ocupado), .fim(fim)
    );

    assign e_all = {E7, E6, E5, E4, E3, E2, E1, E0};

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, wr_en;
        logic [2:0] wr_addr;
        logic [7:0] wr_data;
        logic       iniciar;
        logic [2:0] primeiro, ultimo;
        logic       ciclico, parar, pronto;
        logic [2:0] x_sinal;
        logic       x_valido, x_ocupado, x_fim;
        int         e_idx;
        logic [7:0] e_val;
    } vetor_t;

    vetor_t tab[15];

    function automatic vetor_t v(logic r, logic we, logic [2:0] wa, logic [7:0] wd,
                                 logic ini, logic [2:0] pr, logic [2:0] ul, logic ci,
                                 logic pa, logic pt, logic [2:0] xs, logic xv,
                                 logic xo, logic xf, int ei, logic [7:0] ev);
        vetor_t t;
        t.rst = r; t.wr_en = we; t.wr_addr = wa; t.wr_data = wd;
        t.iniciar = ini; t.primeiro = pr; t.ultimo = ul; t.ciclico = ci;
        t.parar = pa; t.pronto = pt;
        t.x_sinal = xs; t.x_valido = xv; t.x_ocupado = xo; t.x_fim = xf;
        t.e_idx = ei; t.e_val = ev;
        return t;
    endfunction

    task automatic chk(string nome, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nome, act, exp);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic limpa();
        rst = 0; wr_en = 0; iniciar = 0; parar = 0; pronto = 0; ciclico = 0;
    endtask

    task automatic estado_chk(string nome, int s, int vv, int o, int f);
        chk({nome, ".sinal"}, Sinal, s);
        chk({nome, ".valido"}, valido, vv);
        chk({nome, ".ocupado"}, ocupado, o);
        chk({nome, ".fim"}, fim, f);
    endtask

    int ntr;
    int exp_a[6] = '{7, 7, 0, 0, 1, 1};

    initial begin
        // reset with write and start pending, load bank, single pass 2..5
        tab[0]  = v(1, 1, 3, 8'h55, 1, 2, 5, 0, 0, 1,  0, 0, 0, 0, 3, 8'h00);
        for (int i = 0; i < 8; i++)
            tab[1+i] = v(0, 1, 3'(i), 8'(8'h10 + i), 0, 0, 0, 0, 0, 0,
                         0, 0, 0, 0, i, 8'(8'h10 + i));
        tab[9]  = v(0, 0, 0, 0, 1, 2, 5, 0, 0, 1,  2, 1, 1, 0, 2, 8'h12);
        tab[10] = v(0, 0, 0, 0, 0, 7, 7, 1, 0, 1,  3, 1, 1, 0, 3, 8'h13);
        tab[11] = v(0, 0, 0, 0, 0, 7, 7, 1, 0, 1,  4, 1, 1, 0, 4, 8'h14);
        tab[12] = v(0, 0, 0, 0, 0, 7, 7, 1, 0, 1,  5, 1, 1, 0, 5, 8'h15);
        tab[13] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  5, 0, 1, 1, 7, 8'h17);
        tab[14] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  5, 0, 0, 0, 0, 8'h10);

        ciclo();
        for (int k = 0; k < 15; k++) begin
            rst = tab[k].rst; wr_en = tab[k].wr_en; wr_addr = tab[k].wr_addr;
            wr_data = tab[k].wr_data; iniciar = tab[k].iniciar;
            primeiro = tab[k].primeiro; ultimo = tab[k].ultimo;
            ciclico = tab[k].ciclico; parar = tab[k].parar; pronto = tab[k].pronto;
            ciclo();
            estado_chk($sformatf("vec%0d", k), tab[k].x_sinal, tab[k].x_valido,
                       tab[k].x_ocupado, tab[k].x_fim);
            chk($sformatf("vec%0d.E%0d", k, tab[k].e_idx), e_all[tab[k].e_idx], tab[k].e_val);
        end
        limpa();

        // wrap 6..1 with pronto alternating 1,0
        iniciar = 1; primeiro = 6; ultimo = 1; ciclico = 0;
        ciclo();
        iniciar = 0;
        estado_chk("wrap.start", 6, 1, 1, 0);
        ntr = 0;
        for (int i = 0; i < 6; i++) begin
            pronto = (i % 2 == 0);
            if (valido && pronto) ntr++;
            ciclo();
            estado_chk($sformatf("wrap.s%0d", i), exp_a[i], 1, 1, 0);
        end
        pronto = 1;
        if (valido && pronto) ntr++;
        ciclo();
        estado_chk("wrap.fim", 1, 0, 1, 1);
        chk("wrap.transfers", ntr, 4);
        // start during FIM is ignored
        iniciar = 1; primeiro = 2; ultimo = 2;
        ciclo();
        estado_chk("fim.ignora", 1, 0, 0, 0);
        // single-index range accepted right after FIM
        primeiro = 4; ultimo = 4;
        ciclo();
        iniciar = 0;
        estado_chk("um.start", 4, 1, 1, 0);
        ciclo();
        estado_chk("um.fim", 4, 0, 1, 1);
        ciclo();
        estado_chk("um.idle", 4, 0, 0, 0);
        limpa();

        // cyclic 3..4 then abort on a transfer edge
        iniciar = 1; primeiro = 3; ultimo = 4; ciclico = 1; pronto = 1;
        ciclo();
        iniciar = 0; ciclico = 0;
        estado_chk("cic.start", 3, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            ciclo();
            estado_chk($sformatf("cic.s%0d", i), (i % 2 == 0) ? 4 : 3, 1, 1, 0);
        end
        parar = 1;
        ciclo();
        parar = 0;
        estado_chk("cic.parar", 3, 0, 0, 0);
        ciclo();
        estado_chk("cic.depois", 3, 0, 0, 0);
        limpa();

        // second start ignored mid-scan; write to selected entry
        iniciar = 1; primeiro = 0; ultimo = 7;
        ciclo();
        estado_chk("ign.start", 0, 1, 1, 0);
        primeiro = 5; ultimo = 5;
        ciclo();
        estado_chk("ign.ini2", 0, 1, 1, 0);
        iniciar = 0; pronto = 1;
        ciclo();
        estado_chk("ign.s1", 1, 1, 1, 0);
        pronto = 0; wr_en = 1; wr_addr = 1; wr_data = 8'hAA;
        ciclo();
        wr_en = 0;
        estado_chk("wr.hold", 1, 1, 1, 0);
        chk("wr.E1", e_all[1], 8'hAA);
        pronto = 1;
        for (int i = 2; i < 8; i++) begin
            ciclo();
            estado_chk($sformatf("ign.s%0d", i), i, 1, 1, 0);
        end
        ciclo();
        estado_chk("ign.fim", 7, 0, 1, 1);
        ciclo();
        limpa();

        // reset on third transfer of a 0..7 scan
        iniciar = 1; primeiro = 0; ultimo = 7; pronto = 1;
        ciclo();
        iniciar = 0;
        ciclo();
        ciclo();
        estado_chk("rst.pre", 2, 1, 1, 0);
        rst = 1;
        ciclo();
        rst = 0;
        estado_chk("rst.meio", 0, 0, 0, 0);
        chk("rst.banco", (e_all == '0), 1);
        ciclo();
        estado_chk("rst.depois", 0, 0, 0, 0);
        limpa();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
